// File: rtl/lz77_pkg.sv
// -----------------------------------------------------------------------------
// lz77_pkg
// Shared definitions for the LZ77 stream encoder and its matching decoder:
// the controller state encoding and the default symbol / window geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package lz77_pkg;

    localparam int LZ77_CHAR_W = 8;   // symbol width in bits
    localparam int LZ77_SB_LEN = 9;   // search-buffer depth in symbols
    localparam int LZ77_LA_LEN = 8;   // look-ahead depth in symbols

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SEARCH,
        ST_EMIT
    } lz77_state_t;

endpackage

// File: rtl/lz77_match_len.sv
// -----------------------------------------------------------------------------
// lz77_match_len
// Combinational match length of one candidate against the look-ahead.
// Counts leading positions where the candidate symbol equals the look-ahead
// symbol, stopping at the first difference or at the cap.
// Ports:
//   cand_view  in  (LA_LEN-1) x CHAR_W  symbols starting at the candidate
//   la_view    in  (LA_LEN-1) x CHAR_W  symbols starting at look-ahead start
//   cap        in  LEN_W                maximum length allowed (la_cnt-1)
//   len        out LEN_W                resulting match length
// -----------------------------------------------------------------------------
module lz77_match_len
    import lz77_pkg::*;
#(
    parameter int CHAR_W = LZ77_CHAR_W,
    parameter int LA_LEN = LZ77_LA_LEN,
    parameter int LEN_W  = $clog2(LZ77_LA_LEN)
) (
    input  logic [LA_LEN-2:0][CHAR_W-1:0] cand_view,
    input  logic [LA_LEN-2:0][CHAR_W-1:0] la_view,
    input  logic [LEN_W-1:0]              cap,
    output logic [LEN_W-1:0]              len
);

    logic [LA_LEN-2:0] eq;
    logic              run;

    genvar gi;
    generate
        for (gi = 0; gi < LA_LEN - 1; gi++) begin : g_eq
            assign eq[gi] = (cand_view[gi] == la_view[gi]);
        end
    endgenerate

    // run stays high only while every earlier position matched
    always_comb begin
        len = '0;
        run = 1'b1;
        for (int i = 0; i < LA_LEN - 1; i++) begin
            if (run && eq[i] && (LEN_W'(i) < cap)) begin
                len = len + LEN_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lz77_stream_enc.sv
// -----------------------------------------------------------------------------
// lz77_stream_enc
// Streaming LZ77 encoder. Symbols are collected into a circular window holding
// a search buffer (already encoded) followed by a look-ahead (not yet encoded).
// For each token the search buffer is scanned one candidate per cycle, oldest
// first, and the longest match (earliest on ties) is emitted as
// (offset, length, next symbol).
// Ports:
//   clk         in   clock
//   reset       in   asynchronous active-high reset
//   in_valid    in   symbol offered
//   in_ready    out  symbol accepted this cycle
//   in_char     in   CHAR_W symbol
//   in_last     in   final symbol of the stream
//   out_valid   out  token valid
//   out_ready   in   token consumed
//   out_offset  out  OFF_W match distance minus 1
//   out_len     out  LEN_W match length
//   out_char    out  CHAR_W symbol following the match
//   out_last    out  token consumes the final symbol
//   busy        out  stream in progress
// -----------------------------------------------------------------------------
module lz77_stream_enc
    import lz77_pkg::*;
#(
    parameter int  CHAR_W = LZ77_CHAR_W,
    parameter int  SB_LEN = LZ77_SB_LEN,
    parameter int  LA_LEN = LZ77_LA_LEN,
    localparam int OFF_W  = $clog2(SB_LEN),
    localparam int LEN_W  = $clog2(LA_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OFF_W-1:0]  out_offset,
    output logic [LEN_W-1:0]  out_len,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_last,
    output logic              busy
);

    // window is the smallest power of two holding both regions
    localparam int PTR_W = $clog2(SB_LEN + LA_LEN);
    localparam int WIN   = 1 << PTR_W;
    localparam int SBC_W = $clog2(SB_LEN + 1);
    localparam int LAC_W = $clog2(LA_LEN + 1);
    localparam int SUM_W = PTR_W + 1;

    lz77_state_t       state;
    logic [PTR_W-1:0]  la_ptr;        // look-ahead start in the window
    logic [SBC_W-1:0]  sb_cnt;
    logic [LAC_W-1:0]  la_cnt;
    logic [SBC_W-1:0]  search_idx;    // candidate number, 0 = oldest
    logic              last_seen;     // in_last has been accepted
    logic [LEN_W-1:0]  best_len;
    logic [OFF_W-1:0]  best_off;

    logic [CHAR_W-1:0] window [WIN];

    logic                         wr_en;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             cand_ptr;
    logic [LA_LEN-1:0][CHAR_W-1:0] la_view;
    logic [LA_LEN-2:0][CHAR_W-1:0] cand_view;
    logic [LEN_W-1:0]             cap;
    logic [LEN_W-1:0]             cand_len;
    logic [OFF_W-1:0]             cand_off;
    logic                         better;
    logic [LEN_W-1:0]             fin_len;
    logic [OFF_W-1:0]             fin_off;
    logic                         last_cand;
    logic [LAC_W-1:0]             la_after_search;
    logic [LAC_W-1:0]             la_after_emit;
    logic [SUM_W-1:0]             sb_sum;
    logic [SBC_W-1:0]             sb_after_emit;

    // gated by reset so nothing is accepted while reset is held
    assign in_ready = !reset &&
                      ((state == ST_IDLE) ||
                       (state == ST_FILL && la_cnt < LAC_W'(LA_LEN) && !last_seen));
    assign wr_en    = in_valid && in_ready;
    assign wr_ptr   = la_ptr + PTR_W'(la_cnt);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            window[wr_ptr] <= in_char;
        end
    end

    // candidates run from the oldest search-buffer entry toward the look-ahead
    assign cand_ptr = la_ptr - PTR_W'(sb_cnt) + PTR_W'(search_idx);

    genvar gi;
    generate
        for (gi = 0; gi < LA_LEN; gi++) begin : g_la_view
            assign la_view[gi] = window[la_ptr + PTR_W'(gi)];
        end
        // may read into the look-ahead itself, which yields overlapping matches
        for (gi = 0; gi < LA_LEN - 1; gi++) begin : g_cand_view
            assign cand_view[gi] = window[cand_ptr + PTR_W'(gi)];
        end
    endgenerate

    assign cap = LEN_W'(la_cnt - LAC_W'(1));

    lz77_match_len #(
        .CHAR_W (CHAR_W),
        .LA_LEN (LA_LEN),
        .LEN_W  (LEN_W)
    ) u_match_len (
        .cand_view (cand_view),
        .la_view   (la_view[LA_LEN-2:0]),
        .cap       (cap),
        .len       (cand_len)
    );

    assign cand_off  = OFF_W'(sb_cnt - search_idx - SBC_W'(1));
    // strictly longer only, so ties keep the older (larger offset) candidate
    assign better    = (sb_cnt != '0) && (cand_len > best_len);
    assign fin_len   = better ? cand_len : best_len;
    assign fin_off   = better ? cand_off : best_off;
    // an empty search buffer still spends one cycle here
    assign last_cand = (sb_cnt == '0) || (search_idx == sb_cnt - SBC_W'(1));

    assign la_after_search = la_cnt - LAC_W'(fin_len) - LAC_W'(1);
    assign la_after_emit   = la_cnt - LAC_W'(out_len) - LAC_W'(1);
    assign sb_sum          = SUM_W'(sb_cnt) + SUM_W'(out_len) + SUM_W'(1);
    assign sb_after_emit   = (sb_sum > SUM_W'(SB_LEN)) ? SBC_W'(SB_LEN) : SBC_W'(sb_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            la_ptr     <= '0;
            sb_cnt     <= '0;
            la_cnt     <= '0;
            search_idx <= '0;
            last_seen  <= 1'b0;
            best_len   <= '0;
            best_off   <= '0;
            out_valid  <= 1'b0;
            out_offset <= '0;
            out_len    <= '0;
            out_char   <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_en) begin
                        la_cnt    <= LAC_W'(1);
                        last_seen <= in_last;
                        busy      <= 1'b1;
                        state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (la_cnt == LAC_W'(LA_LEN) || last_seen) begin
                        search_idx <= '0;
                        best_len   <= '0;
                        best_off   <= '0;
                        state      <= ST_SEARCH;
                    end else if (wr_en) begin
                        la_cnt <= la_cnt + LAC_W'(1);
                        if (in_last) begin
                            last_seen <= 1'b1;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (last_cand) begin
                        out_offset <= fin_off;
                        out_len    <= fin_len;
                        out_char   <= la_view[fin_len];
                        out_last   <= last_seen && (la_after_search == '0);
                        out_valid  <= 1'b1;
                        state      <= ST_EMIT;
                    end else begin
                        search_idx <= search_idx + SBC_W'(1);
                        best_len   <= fin_len;
                        best_off   <= fin_off;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        la_ptr     <= la_ptr + PTR_W'(out_len) + PTR_W'(1);
                        la_cnt     <= la_after_emit;
                        search_idx <= '0;
                        best_len   <= '0;
                        best_off   <= '0;
                        if (la_after_emit == '0 && last_seen) begin
                            sb_cnt    <= '0;
                            busy      <= 1'b0;
                            last_seen <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            sb_cnt <= sb_after_emit;
                            state  <= last_seen ? ST_SEARCH : ST_FILL;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_stream_enc.sv
// -----------------------------------------------------------------------------
// tb_lz77_stream_enc
// Directed bench for lz77_stream_enc with default geometry (8/9/8). Streams
// are fed symbol by symbol and every emitted token is compared with a
// hand-computed (offset, length, char, last) tuple.
// -----------------------------------------------------------------------------
module tb_lz77_stream_enc;
    import lz77_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_char = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_offset;
    logic [2:0] out_len;
    logic [7:0] out_char;
    logic       out_last;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned stim[$];
    logic [31:0]  exp_tok[$];

    always #5 clk = ~clk;

    lz77_stream_enc #(
        .CHAR_W (8),
        .SB_LEN (9),
        .LA_LEN (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_offset (out_offset),
        .out_len    (out_len),
        .out_char   (out_char),
        .out_last   (out_last),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tk(input int off, input int len, input byte unsigned c, input bit lst);
        return {8'(off), 8'(len), c, 7'd0, lst};
    endfunction

    function automatic logic [31:0] obs_tok();
        return {8'(out_offset), 8'(out_len), out_char, 7'd0, out_last};
    endfunction

    function automatic logic [31:0] reset_vec();
        return 32'({in_ready, out_valid, out_last, busy, out_offset, out_len, out_char});
    endfunction

    task automatic load(input string s);
        stim.delete();
        exp_tok.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    // Feeds stim and collects tokens; starts and ends at a negedge.
    task automatic run_stream(input string name, input int stall_tok, input int exp_sb);
        int idx, tok, stall, n, ntok;
        n = stim.size();
        ntok = exp_tok.size();
        idx = 0;
        tok = 0;
        stall = 0;
        for (int cyc = 0; cyc < 3000 && tok < ntok; cyc++) begin
            in_valid  = (idx < n);
            in_char   = (idx < n) ? stim[idx] : 8'h00;
            in_last   = (idx == n - 1);
            out_ready = !(tok == stall_tok && stall < 5);
            #1;
            if (out_valid) begin
                if (!out_ready) begin
                    check_eq($sformatf("%s_hold%0d", name, stall), obs_tok(), exp_tok[tok]);
                    check_eq($sformatf("%s_hold_in_ready%0d", name, stall), 32'(in_ready), 32'd0);
                    stall++;
                end else begin
                    $display("tok %s[%0d] off=%0d len=%0d chr=%h last=%0b",
                             name, tok, out_offset, out_len, out_char, out_last);
                    check_eq($sformatf("%s_tok%0d", name, tok), obs_tok(), exp_tok[tok]);
                    if (tok == ntok - 1) begin
                        check_eq($sformatf("%s_busy_last", name), 32'(busy), 32'd1);
                        if (exp_sb >= 0)
                            check_eq($sformatf("%s_sb_sat", name), 32'(dut.sb_cnt), 32'(exp_sb));
                    end
                    tok++;
                end
            end
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check_eq($sformatf("%s_token_count", name), 32'(tok), 32'(ntok));
        #1;
        check_eq($sformatf("%s_busy_after", name), 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, n;
        bit found;

        // power-on reset
        repeat (3) @(negedge clk);
        check_eq("reset_state", reset_vec(), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_ready_busy", 32'({in_ready, busy}), 32'b10);

        load("aab");
        exp_tok.push_back(tk(0, 0, "a", 1'b0));
        exp_tok.push_back(tk(0, 1, "b", 1'b1));
        run_stream("aab", -1, -1);

        load("aaaaa");
        exp_tok.push_back(tk(0, 0, "a", 1'b0));
        exp_tok.push_back(tk(0, 3, "a", 1'b1));
        run_stream("aaaaa", -1, -1);

        // first token held back for 5 cycles
        load("abcabcabcx");
        exp_tok.push_back(tk(0, 0, "a", 1'b0));
        exp_tok.push_back(tk(0, 0, "b", 1'b0));
        exp_tok.push_back(tk(0, 0, "c", 1'b0));
        exp_tok.push_back(tk(2, 6, "x", 1'b1));
        run_stream("abcx", 0, -1);

        load("ABCDEFGHIJKLMNOPQRST");
        for (int i = 0; i < 20; i++)
            exp_tok.push_back(tk(0, 0, 8'(8'h41 + i), (i == 19)));
        run_stream("distinct20", -1, 9);

        // reset while the first search is in progress
        load("abcabcabcx");
        n = stim.size();
        idx = 0;
        found = 1'b0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            if (dut.state == ST_SEARCH) begin
                found = 1'b1;
            end else begin
                in_valid = (idx < n);
                in_char  = (idx < n) ? stim[idx] : 8'h00;
                in_last  = (idx == n - 1);
                #1;
                if (in_valid && in_ready) idx++;
                @(negedge clk);
            end
        end
        check_eq("reach_search", 32'(found), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("midstream_reset%0d", i), reset_vec(), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        load("ab");
        exp_tok.push_back(tk(0, 0, "a", 1'b0));
        exp_tok.push_back(tk(0, 0, "b", 1'b1));
        run_stream("post_reset_ab", -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lz77_stream_enc.md
LZ77_STREAM_ENC -- requirements
Module: lz77_stream_enc

Interface
REQ-001 SHALL have parameter CHAR_W, default 8, symbol width in bits.
REQ-002 SHALL have parameter SB_LEN, default 9, search-buffer depth in symbols (2..15).
REQ-003 SHALL have parameter LA_LEN, default 8, look-ahead depth in symbols (2..15).
REQ-004 SHALL derive OFF_W = clog2(SB_LEN) and LEN_W = clog2(LA_LEN), both local.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: in_valid  in  1  symbol offered; in_ready  out  1  symbol accepted this cycle; in_char  in  CHAR_W  symbol; in_last  in  1  final symbol of stream.
REQ-007 SHALL have ports: out_valid  out  1  token valid; out_ready  in  1  token consumed; out_offset  out  OFF_W  match distance minus 1; out_len  out  LEN_W  match length; out_char  out  CHAR_W  next symbol; out_last  out  1  final token; busy  out  1  stream in progress.

Function
REQ-008 SHALL hold symbols in a circular window of 2^k >= SB_LEN+LA_LEN entries, with counters sb_cnt (0..SB_LEN) and la_cnt (0..LA_LEN).
REQ-009 SHALL implement states IDLE, FILL, SEARCH, EMIT.
REQ-010 IDLE: in_ready=1; first in_valid moves to FILL with that symbol stored; busy=1 from the next cycle.
REQ-011 FILL: in_ready=1 while la_cnt<LA_LEN and in_last not yet accepted; on a handshake, la_cnt increments.
REQ-012 FILL->SEARCH when la_cnt==LA_LEN or a symbol with in_last=1 has been accepted.
REQ-013 SEARCH: evaluate one candidate start per cycle, oldest first, for max(sb_cnt,1) cycles; in_ready=0.
REQ-014 Candidate length = number of consecutive equal symbols, capped at la_cnt-1; comparison may run into the look-ahead region (overlap allowed).
REQ-015 Best match is strictly the longest; on a tie the earlier-found (larger offset) candidate is kept; sb_cnt==0 or no match gives len=0, offset=0.
REQ-016 out_offset = (look-ahead start - match start - 1); out_char = look-ahead symbol at index len.
REQ-017 SEARCH->EMIT after the last candidate; out_valid asserts in EMIT; all out_* are held stable until out_ready=1.
REQ-018 On EMIT handshake, the block SHALL advance look-ahead start by len+1; la_cnt -= len+1; sb_cnt = min(sb_cnt+len+1, SB_LEN).
REQ-019 After EMIT: if la_cnt becomes 0 and last was accepted -> IDLE, sb_cnt=0, busy=0; else if last was accepted -> SEARCH; else -> FILL.
REQ-020 out_last=1 only on the token that consumes the final symbol.
REQ-021 Outside EMIT, out_valid=0 and out_* SHALL keep their previous values.

Reset
REQ-022 Reset SHALL force IDLE, in_ready=0 during reset, out_valid=0, out_last=0, busy=0, out_offset=0, out_len=0, out_char=0, sb_cnt=la_cnt=0, and pointers to 0.
REQ-023 Reset asserted mid-stream SHALL discard all buffered symbols and pending tokens; the first token after reset SHALL reflect only post-reset input.

Structure
REQ-024 Shared package lz77_pkg SHALL hold the state enum and default CHAR_W/SB_LEN/LA_LEN constants, for reuse by the decoder.
REQ-025 Sub-module lz77_match_len SHALL compute, combinationally, a single candidate's capped match length from window and look-ahead views.

Verification
REQ-026 Stream "aab" (last on 'b'), out_ready=1 -> tokens (0,0,'a'), (0,1,'b',last).
REQ-027 Stream "aaaaa" -> (0,0,'a'), then (0,3,'a',last) via overlapping match capped at la_cnt-1.
REQ-028 Stream "abcabcabcx", SB_LEN=9, LA_LEN=8 -> (0,0,'a'), (0,0,'b'), (0,0,'c'), (2,6,'x',last).
REQ-029 Hold out_ready=0 for 5 cycles on any token -> out_valid and out_* stay constant and in_ready stays 0.
REQ-030 20 distinct symbols -> 20 tokens each (0,0,sym), sb_cnt saturates at 9, last token out_last=1, busy drops 1 cycle later.
REQ-031 Assert reset during SEARCH, then send "ab" -> all outputs 0 during reset, then (0,0,'a'), (0,0,'b',last).
